// File: rtl/sort_batch_ctrl.sv
// In-place 4-word block sorter controller: read block, wait for sorter, write back.
// Optional sortedness checker enabled by macro SORT_ORDER_CHECK_EN; per block 9+LAT cycles.
module sort_batch_ctrl #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 9,
   parameter int LAT    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-3:0] num_blocks,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [WIDTH-1:0]  mem_rd_data,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [WIDTH-1:0]  mem_wr_data,
   output logic [WIDTH-1:0]  sort_in0,
   output logic [WIDTH-1:0]  sort_in1,
   output logic [WIDTH-1:0]  sort_in2,
   output logic [WIDTH-1:0]  sort_in3,
   input  logic [WIDTH-1:0]  sort_out0,
   input  logic [WIDTH-1:0]  sort_out1,
   input  logic [WIDTH-1:0]  sort_out2,
   input  logic [WIDTH-1:0]  sort_out3,
   output logic              order_err
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

   localparam int              LW      = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam logic [LW-1:0]   LAT_L   = LW'(LAT);
   localparam logic [LW-1:0]   LAT_ONE = 1;
   localparam logic [ADDR_W-3:0] BLK_ONE = 1;

   state_t              state_q;
   logic [1:0]          cnt_q;
   logic [LW-1:0]       lat_q;
   logic [ADDR_W-3:0]   blk_q, nblk_q;
   logic [ADDR_W-1:0]   base_q;
   logic [WIDTH-1:0]    stage_q [4];
   logic [WIDTH-1:0]    res_q [4];
   logic                cap_en_q;
   logic [1:0]          cap_idx_q;
   logic                busy_q, done_q, rd_en_q, wr_en_q;
   logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
   logic [WIDTH-1:0]    wr_data_q;

   logic [WIDTH-1:0]    sort_out_a [4];
   logic [ADDR_W-3:0]   blk_d;
   logic [1:0]          cnt_d;
   logic [ADDR_W-1:0]   cur_base_d, nxt_base_d, cnt_off_d;

   assign blk_d      = blk_q + BLK_ONE;
   assign cnt_d      = cnt_q + 2'd1;
   assign cur_base_d = base_q + {blk_q, 2'b00};
   assign nxt_base_d = base_q + {blk_d, 2'b00};
   assign cnt_off_d  = {{(ADDR_W-2){1'b0}}, cnt_d};

   assign sort_out_a[0] = sort_out0;
   assign sort_out_a[1] = sort_out1;
   assign sort_out_a[2] = sort_out2;
   assign sort_out_a[3] = sort_out3;

`ifdef SORT_ORDER_CHECK_EN
   logic oerr_q;
   assign order_err = oerr_q;
`else
   assign order_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         lat_q     <= '0;
         blk_q     <= '0;
         nblk_q    <= '0;
         base_q    <= '0;
         cap_en_q  <= 1'b0;
         cap_idx_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         for (int k = 0; k < 4; k++) begin
            stage_q[k] <= '0;
            res_q[k]   <= '0;
         end
`ifdef SORT_ORDER_CHECK_EN
         oerr_q    <= 1'b0;
`endif
      end else begin
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
         // Read data lands one cycle after its request; remember which slot it belongs to.
         cap_en_q  <= rd_en_q;
         cap_idx_q <= cnt_q;
         if (cap_en_q) stage_q[cap_idx_q] <= mem_rd_data;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_q <= base_addr;
                  nblk_q <= num_blocks;
                  blk_q  <= '0;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
`ifdef SORT_ORDER_CHECK_EN
                  oerr_q <= 1'b0;
`endif
                  if (num_blocks != '0) begin
                     state_q   <= S_READ;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= base_addr;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (cnt_q == 2'd3) begin
                  state_q <= S_WAIT;
                  lat_q   <= '0;
               end else begin
                  cnt_q     <= cnt_d;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= cur_base_d + cnt_off_d;
               end
            end
            S_WAIT: begin
               if (lat_q == LAT_L) begin
                  for (int k = 0; k < 4; k++) res_q[k] <= sort_out_a[k];
`ifdef SORT_ORDER_CHECK_EN
                  if (sort_out0 > sort_out1 || sort_out1 > sort_out2 || sort_out2 > sort_out3)
                     oerr_q <= 1'b1;
`endif
                  state_q   <= S_WRITE;
                  cnt_q     <= '0;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= cur_base_d;
                  wr_data_q <= sort_out0;
               end else begin
                  lat_q <= lat_q + LAT_ONE;
               end
            end
            S_WRITE: begin
               if (cnt_q == 2'd3) begin
                  blk_q <= blk_d;
                  cnt_q <= '0;
                  if (blk_d < nblk_q) begin
                     state_q   <= S_READ;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= nxt_base_d;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  cnt_q     <= cnt_d;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= cur_base_d + cnt_off_d;
                  wr_data_q <= res_q[cnt_d];
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign mem_rd_en   = rd_en_q;
   assign mem_rd_addr = rd_addr_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;
   assign sort_in0    = stage_q[0];
   assign sort_in1    = stage_q[1];
   assign sort_in2    = stage_q[2];
   // Word 3 arrives during the first WAIT cycle; bypass it so a zero-latency sorter sees it.
   assign sort_in3    = (cap_en_q && cap_idx_q == 2'd3) ? mem_rd_data : stage_q[3];

endmodule

// File: tb/tb_sort_batch_ctrl.sv
// Directed bench for sort_batch_ctrl: one LAT=0 and one LAT=2 instance, each with
// its own memory and sorter model; checks sorted results, timing, reset and order_err.
module tb_sort_batch_ctrl;

   localparam int AW = 9;
`ifdef SORT_ORDER_CHECK_EN
   localparam logic EXP_OE = 1'b1;
`else
   localparam logic EXP_OE = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, start0, start2;
   logic [AW-1:0]   base_addr;
   logic [AW-3:0]   num_blocks;

   logic            busy0, done0, rd_en0, wr_en0, oe0;
   logic [AW-1:0]   rd_addr0, wr_addr0;
   logic [31:0]     rd_data0, wr_data0;
   logic [3:0][31:0] si0, so0;

   logic            busy2, done2, rd_en2, wr_en2, oe2;
   logic [AW-1:0]   rd_addr2, wr_addr2;
   logic [31:0]     rd_data2, wr_data2;
   logic [3:0][31:0] si2, so2, p1, p2;

   logic [31:0]     mem0 [512];
   logic [31:0]     mem2 [512];
   logic            tb_we, tb_sel, force_bad, cur_sel;
   logic [AW-1:0]   tb_addr;
   logic [31:0]     tb_data;

   int rdc0 = 0, wrc0 = 0, bzc0 = 0, ovc0 = 0, dnc0 = 0;
   int rdc2 = 0, wrc2 = 0, bzc2 = 0, ovc2 = 0, dnc2 = 0;
   int n_pass = 0, n_chk = 0;

   sort_batch_ctrl #(.WIDTH(32), .ADDR_W(AW), .LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .base_addr(base_addr), .num_blocks(num_blocks),
      .busy(busy0), .done(done0), .mem_rd_en(rd_en0), .mem_rd_addr(rd_addr0),
      .mem_rd_data(rd_data0), .mem_wr_en(wr_en0), .mem_wr_addr(wr_addr0),
      .mem_wr_data(wr_data0), .sort_in0(si0[0]), .sort_in1(si0[1]), .sort_in2(si0[2]),
      .sort_in3(si0[3]), .sort_out0(so0[0]), .sort_out1(so0[1]), .sort_out2(so0[2]),
      .sort_out3(so0[3]), .order_err(oe0));

   sort_batch_ctrl #(.WIDTH(32), .ADDR_W(AW), .LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr), .num_blocks(num_blocks),
      .busy(busy2), .done(done2), .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2),
      .mem_rd_data(rd_data2), .mem_wr_en(wr_en2), .mem_wr_addr(wr_addr2),
      .mem_wr_data(wr_data2), .sort_in0(si2[0]), .sort_in1(si2[1]), .sort_in2(si2[2]),
      .sort_in3(si2[3]), .sort_out0(so2[0]), .sort_out1(so2[1]), .sort_out2(so2[2]),
      .sort_out3(so2[3]), .order_err(oe2));

   function automatic logic [3:0][31:0] sort4(input logic [3:0][31:0] v);
      logic [31:0] t;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3 - i; j++)
            if (v[j] > v[j+1]) begin
               t = v[j]; v[j] = v[j+1]; v[j+1] = t;
            end
      return v;
   endfunction

   always_comb begin
      so0 = sort4(si0);
      if (force_bad) begin
         so0[0] = 32'd5; so0[1] = 32'd3; so0[2] = 32'd6; so0[3] = 32'd7;
      end
   end

   always @(posedge clk) begin
      p1 <= sort4(si2);
      p2 <= p1;
   end
   assign so2 = p2;

   always @(posedge clk) begin
      if (tb_we && !tb_sel) mem0[tb_addr] <= tb_data;
      if (tb_we && tb_sel)  mem2[tb_addr] <= tb_data;
      if (wr_en0) mem0[wr_addr0] <= wr_data0;
      if (wr_en2) mem2[wr_addr2] <= wr_data2;
      if (rd_en0) rd_data0 <= mem0[rd_addr0];
      if (rd_en2) rd_data2 <= mem2[rd_addr2];
      rdc0 <= rdc0 + int'(rd_en0);  wrc0 <= wrc0 + int'(wr_en0);
      bzc0 <= bzc0 + int'(busy0);   dnc0 <= dnc0 + int'(done0);
      ovc0 <= ovc0 + int'(rd_en0 && wr_en0);
      rdc2 <= rdc2 + int'(rd_en2);  wrc2 <= wrc2 + int'(wr_en2);
      bzc2 <= bzc2 + int'(busy2);   dnc2 <= dnc2 + int'(done2);
      ovc2 <= ovc2 + int'(rd_en2 && wr_en2);
   end

   logic          busy_s, done_s, rd_en_s, wr_en_s, oe_s;
   logic [AW-1:0] rd_addr_s, wr_addr_s;
   logic [31:0]   wr_data_s, sin_or_s;
   int            rdc_s, wrc_s, bzc_s, ovc_s, dnc_s;
   assign busy_s    = cur_sel ? busy2 : busy0;
   assign done_s    = cur_sel ? done2 : done0;
   assign rd_en_s   = cur_sel ? rd_en2 : rd_en0;
   assign wr_en_s   = cur_sel ? wr_en2 : wr_en0;
   assign oe_s      = cur_sel ? oe2 : oe0;
   assign rd_addr_s = cur_sel ? rd_addr2 : rd_addr0;
   assign wr_addr_s = cur_sel ? wr_addr2 : wr_addr0;
   assign wr_data_s = cur_sel ? wr_data2 : wr_data0;
   assign sin_or_s  = cur_sel ? (si2[0] | si2[1] | si2[2] | si2[3])
                              : (si0[0] | si0[1] | si0[2] | si0[3]);
   assign rdc_s = cur_sel ? rdc2 : rdc0;
   assign wrc_s = cur_sel ? wrc2 : wrc0;
   assign bzc_s = cur_sel ? bzc2 : bzc0;
   assign ovc_s = cur_sel ? ovc2 : ovc0;
   assign dnc_s = cur_sel ? dnc2 : dnc0;

   typedef struct {
      logic             sel;
      logic [AW-1:0]    base;
      logic [AW-3:0]    nblk;
      int               mid;
      int               cyc;
      logic [11:0][31:0] din;
      logic [11:0][31:0] dout;
   } vec_t;

   vec_t vecs[4];
   vec_t hv;

   function automatic vec_t put_blk(input vec_t v, input int b,
                                    input logic [31:0] i0, i1, i2, i3, o0, o1, o2, o3);
      v.din[b*4+0] = i0; v.din[b*4+1] = i1; v.din[b*4+2] = i2; v.din[b*4+3] = i3;
      v.dout[b*4+0] = o0; v.dout[b*4+1] = o1; v.dout[b*4+2] = o2; v.dout[b*4+3] = o3;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"},    busy_s, 0);
      chk({tag, "_done"},    done_s, 0);
      chk({tag, "_rd_en"},   rd_en_s, 0);
      chk({tag, "_wr_en"},   wr_en_s, 0);
      chk({tag, "_rd_addr"}, rd_addr_s, 0);
      chk({tag, "_wr_addr"}, wr_addr_s, 0);
      chk({tag, "_wr_data"}, wr_data_s, 0);
      chk({tag, "_sort_in"}, sin_or_s, 0);
      chk({tag, "_order_err"}, oe_s, 0);
   endtask

   task automatic poke(input logic sel, input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      tb_sel = sel; tb_addr = a; tb_data = d; tb_we = 1'b1;
      @(posedge clk);
      #1 tb_we = 1'b0;
   endtask

   task automatic pulse_start(input logic sel);
      if (sel) start2 = 1'b1;
      else     start0 = 1'b1;
   endtask

   task automatic run_job(input vec_t v);
      int cyc, rd_b, wr_b, bz_b, ov_b;
      logic [AW-1:0] a;
      cur_sel = v.sel;
      for (int k = 0; k < 4 * int'(v.nblk); k++) poke(v.sel, v.base + AW'(k), v.din[k]);
      rd_b = rdc_s; wr_b = wrc_s; bz_b = bzc_s; ov_b = ovc_s;
      @(negedge clk);
      base_addr = v.base; num_blocks = v.nblk; pulse_start(v.sel);
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0; cyc = 1;
      while (done_s !== 1'b1 && cyc < 100) begin
         if (v.mid != 0 && cyc == v.mid) begin
            base_addr = 9'h1F0; num_blocks = 7'd5; pulse_start(v.sel);
         end
         @(negedge clk);
         start0 = 1'b0; start2 = 1'b0; cyc++;
      end
      chk("job_cycles", cyc, v.cyc);
      chk("busy_at_done", busy_s, 1);
      @(negedge clk);
      chk("done_one_cycle", done_s, 0);
      chk("busy_after_done", busy_s, 0);
      chk("rd_count", rdc_s - rd_b, 4 * int'(v.nblk));
      chk("wr_count", wrc_s - wr_b, 4 * int'(v.nblk));
      chk("busy_cycles", bzc_s - bz_b, v.cyc);
      chk("rd_wr_overlap", ovc_s - ov_b, 0);
      for (int k = 0; k < 4 * int'(v.nblk); k++) begin
         a = v.base + AW'(k);
         chk($sformatf("word_%0h", a), cur_sel ? mem2[a] : mem0[a], v.dout[k]);
      end
   endtask

   initial begin
      int cyc, dc, rd_b, wr_b;
      rst = 1'b1; start0 = 1'b0; start2 = 1'b0; base_addr = '0; num_blocks = '0;
      tb_we = 1'b0; tb_sel = 1'b0; tb_addr = '0; tb_data = '0; force_bad = 1'b0; cur_sel = 1'b0;

      vecs[0] = '{sel: 1'b0, base: 9'h000, nblk: 7'd1, mid: 0, cyc: 10, din: '0, dout: '0};
      vecs[0] = put_blk(vecs[0], 0, 4, 3, 2, 1, 1, 2, 3, 4);
      vecs[1] = '{sel: 1'b0, base: 9'h1FE, nblk: 7'd1, mid: 0, cyc: 10, din: '0, dout: '0};
      vecs[1] = put_blk(vecs[1], 0, 9, 7, 8, 6, 6, 7, 8, 9);
      vecs[2] = '{sel: 1'b1, base: 9'h010, nblk: 7'd3, mid: 15, cyc: 34, din: '0, dout: '0};
      vecs[2] = put_blk(vecs[2], 0, 30, 10, 40, 20, 10, 20, 30, 40);
      vecs[2] = put_blk(vecs[2], 1, 7, 7, 3, 100, 3, 7, 7, 100);
      vecs[2] = put_blk(vecs[2], 2, 32'hDEAD, 1, 32'hBEEF, 0, 0, 1, 32'hBEEF, 32'hDEAD);
      vecs[3] = '{sel: 1'b0, base: 9'h100, nblk: 7'd2, mid: 0, cyc: 19, din: '0, dout: '0};
      vecs[3] = put_blk(vecs[3], 0, 32'h80000000, 1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                        1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF);
      vecs[3] = put_blk(vecs[3], 1, 5, 5, 0, 5, 0, 5, 5, 5);

      repeat (3) @(negedge clk);
      cur_sel = 1'b0; chk_reset("reset0");
      cur_sel = 1'b1; chk_reset("reset2");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_job(vecs[i]);

      // Empty job: immediate done, no memory traffic.
      cur_sel = 1'b0; rd_b = rdc_s; wr_b = wrc_s;
      @(negedge clk); num_blocks = '0; start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      chk("empty_done", done_s, 1);
      chk("empty_busy", busy_s, 1);
      @(negedge clk);
      chk("empty_done_low", done_s, 0);
      chk("empty_busy_low", busy_s, 0);
      chk("empty_rd", rdc_s - rd_b, 0);
      chk("empty_wr", wrc_s - wr_b, 0);

      // Reset during the second WRITE cycle, with a competing start.
      for (int k = 0; k < 4; k++) poke(1'b0, 9'h040 + AW'(k), 32'(9 - k));
      @(negedge clk); base_addr = 9'h040; num_blocks = 7'd1; start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      repeat (6) @(negedge clk);
      chk("wr2_en", wr_en_s, 1);
      chk("wr2_addr", wr_addr_s, 9'h041);
      chk("wr2_data", wr_data_s, 7);
      rst = 1'b1; start0 = 1'b1; dc = dnc_s;
      @(negedge clk);
      chk_reset("midreset");
      rst = 1'b0; start0 = 1'b0;
      repeat (12) @(negedge clk);
      chk("midreset_no_done", dnc_s - dc, 0);
      chk("midreset_idle", busy_s, 0);
      chk("midreset_w0", mem0[9'h040], 6);
      chk("midreset_w1", mem0[9'h041], 7);
      chk("midreset_w2", mem0[9'h042], 7);
      chk("midreset_w3", mem0[9'h043], 6);
      hv = '{sel: 1'b0, base: 9'h040, nblk: 7'd1, mid: 0, cyc: 10, din: '0, dout: '0};
      hv = put_blk(hv, 0, 6, 7, 7, 6, 6, 6, 7, 7);
      run_job(hv);

      // Unsorted sorter output drives order_err (only when the checker is built).
      cur_sel = 1'b0;
      for (int k = 0; k < 4; k++) poke(1'b0, 9'h080 + AW'(k), 32'(k + 1));
      force_bad = 1'b1;
      @(negedge clk); base_addr = 9'h080; num_blocks = 7'd1; start0 = 1'b1;
      @(negedge clk); start0 = 1'b0; cyc = 1;
      repeat (4) @(negedge clk);
      chk("oe_in_wait", oe_s, 0);
      @(negedge clk); cyc = 6;
      chk("oe_after_wait", oe_s, EXP_OE);
      while (done_s !== 1'b1 && cyc < 40) begin
         @(negedge clk); cyc++;
      end
      chk("oe_job_cycles", cyc, 10);
      chk("oe_at_done", oe_s, EXP_OE);
      force_bad = 1'b0;
      @(negedge clk);
      chk("oe_held_idle", oe_s, EXP_OE);
      num_blocks = '0; start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      chk("oe_cleared_by_start", oe_s, 0);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
